// File: rtl/spio_aer2spinn_mapper.sv
// AER 4-phase active-low bundled-data input to SpiNNaker 72-bit multicast packet converter.
// Define SPIO_AER2SPINN_PARITY_EN to set odd parity in header bit 0.
module spio_aer2spinn_mapper #(
  parameter logic [15:0] KEY_PREFIX = 16'h0200,
  parameter logic [15:0] KEY_OFFSET = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iaer_data,
  input  logic        iaer_req,
  output logic        iaer_ack,
  output logic [71:0] ipkt_data,
  output logic        ipkt_vld,
  input  logic        ipkt_rdy,
  output logic [31:0] evt_cnt
);

  typedef enum logic [1:0] {StResync, StIdle, StAck} state_e;

  state_e      state_q;
  logic        req_meta_q;
  logic        req_s;
  logic [1:0]  settle_q;
  logic        ack_q;
  logic        vld_q;
  logic [71:0] data_q;
  logic [31:0] cnt_q;

  logic        reg_free;
  logic        xfer;
  logic        capture;
  logic [31:0] key;
  logic [7:0]  header;
  logic [71:0] pkt;

  always_comb begin
    reg_free = !vld_q || ipkt_rdy;
    xfer     = vld_q && ipkt_rdy;
    capture  = (state_q == StIdle) && !req_s && reg_free;
    key      = {KEY_PREFIX, iaer_data + KEY_OFFSET};
    header   = 8'h00;
`ifdef SPIO_AER2SPINN_PARITY_EN
    header[0] = ~^key;
`endif
    pkt      = {32'h0000_0000, key, header};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta_q <= 1'b1;
      req_s      <= 1'b1;
      settle_q   <= 2'b00;
      state_q    <= StResync;
      ack_q      <= 1'b1;
      vld_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      req_meta_q <= iaer_req;
      req_s      <= req_meta_q;
      // The synchronizer's reset value is not a real sample of the pin; wait until it has flushed.
      settle_q   <= {settle_q[0], 1'b1};

      if (xfer) begin
        cnt_q <= cnt_q + 32'd1;
      end

      if (capture) begin
        data_q <= pkt;
        vld_q  <= 1'b1;
      end else if (xfer) begin
        vld_q  <= 1'b0;
      end

      case (state_q)
        StResync: begin
          if (settle_q[1] && req_s) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (capture) begin
            ack_q   <= 1'b0;
            state_q <= StAck;
          end
        end
        StAck: begin
          if (req_s) begin
            ack_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          ack_q   <= 1'b1;
          state_q <= StResync;
        end
      endcase
    end
  end

  assign iaer_ack  = ack_q;
  assign ipkt_vld  = vld_q;
  assign ipkt_data = data_q;
  assign evt_cnt   = cnt_q;

endmodule

// File: tb/tb_spio_aer2spinn_mapper.sv
// Self-checking bench for spio_aer2spinn_mapper: directed handshake cases plus randomized
// events scored against a packet-level reference queue.
module tb_spio_aer2spinn_mapper;

  localparam logic [15:0] PREFIX = 16'h0200;
  localparam logic [15:0] OFFSET = 16'h0800;

  logic        clk;
  logic        rst;
  logic [15:0] iaer_data;
  logic        iaer_req;
  logic        iaer_ack;
  logic [71:0] ipkt_data;
  logic        ipkt_vld;
  logic        ipkt_rdy;
  logic [31:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  logic [71:0] exp_q[$];
  bit          rand_rdy = 1'b0;
  bit          hold_q = 1'b0;
  logic [71:0] held;
  logic [71:0] expv;

  spio_aer2spinn_mapper dut (
    .clk       (clk),
    .rst       (rst),
    .iaer_data (iaer_data),
    .iaer_req  (iaer_req),
    .iaer_ack  (iaer_ack),
    .ipkt_data (ipkt_data),
    .ipkt_vld  (ipkt_vld),
    .ipkt_rdy  (ipkt_rdy),
    .evt_cnt   (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  // Packet as the spec describes it: prefix, offset address, odd parity over the low 40 bits.
  function automatic logic [71:0] pkt_model(input logic [15:0] addr);
    logic [15:0] lo;
    logic [31:0] k;
    logic [7:0]  hdr;
    lo  = addr + OFFSET;
    k   = {PREFIX, lo};
    hdr = 8'h00;
`ifdef SPIO_AER2SPINN_PARITY_EN
    if ($countones(k) % 2 == 0) hdr = 8'h01;
`endif
    return {32'd0, k, hdr};
  endfunction

  // SpiNNaker-to-AER output mapper: strips the core-ID offset back off the key.
  function automatic logic [15:0] out_map(input logic [31:0] k);
    return k[15:0] - OFFSET;
  endfunction

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2 ipkt_rdy = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q && ipkt_vld) chk("data_stable", ipkt_data, held);
      if (ipkt_vld && ipkt_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pkt", {71'd0, ipkt_vld}, 72'd0);
        end else begin
          expv = exp_q.pop_front();
          chk("pkt_order", ipkt_data, expv);
        end
      end
      hold_q = ipkt_vld && !ipkt_rdy;
      held   = ipkt_data;
    end
  end

  // Full 4-phase handshake; called at posedge+1.
  task automatic send(input logic [15:0] addr, input bit exact, output logic [71:0] cap);
    int n;
    iaer_data = addr;
    iaer_req  = 1'b0;
    exp_q.push_back(pkt_model(addr));
    n = 0;
    while (iaer_ack !== 1'b0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    cap = ipkt_data;
    chk("ack_fall", {71'd0, iaer_ack}, 72'd0);
    if (exact) chk("ack_fall_lat", 72'(n), 72'd3);
    else       chk("ack_fall_min", {71'd0, n >= 3}, 72'd1);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    iaer_req = 1'b1;
    n = 0;
    while (iaer_ack !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_rise", {71'd0, iaer_ack}, 72'd1);
    chk("ack_rise_lat", 72'(n), 72'd3);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] cap;
    logic [15:0] lb [3];
    bit          bad;
    int          n;

    rst = 1'b1; iaer_req = 1'b1; iaer_data = 16'h0000; ipkt_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {71'd0, iaer_ack}, 72'd1);
    chk("rst_vld", {71'd0, ipkt_vld}, 72'd0);
    chk("rst_data", ipkt_data, 72'd0);
    chk("rst_cnt", 72'(evt_cnt), 72'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single event with exact latency.
    iaer_data = 16'h0012; iaer_req = 1'b0;
    exp_q.push_back(pkt_model(16'h0012));
    repeat (2) @(posedge clk);
    #1;
    chk("edge2_ack", {71'd0, iaer_ack}, 72'd1);
    chk("edge2_vld", {71'd0, ipkt_vld}, 72'd0);
    @(posedge clk); #1;
    chk("edge3_ack", {71'd0, iaer_ack}, 72'd0);
    chk("edge3_vld", {71'd0, ipkt_vld}, 72'd1);
`ifdef SPIO_AER2SPINN_PARITY_EN
    chk("evt12_data", ipkt_data, 72'h00_0000_0002_0008_1201);
`else
    chk("evt12_data", ipkt_data, 72'h00_0000_0002_0008_1200);
`endif
    ipkt_rdy = 1'b1;
    @(posedge clk); #1;
    chk("evt12_vld_clr", {71'd0, ipkt_vld}, 72'd0);
    chk("evt12_cnt", 72'(evt_cnt), 72'd1);
    iaer_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rise_edge2_ack", {71'd0, iaer_ack}, 72'd0);
    @(posedge clk); #1;
    chk("rise_edge3_ack", {71'd0, iaer_ack}, 72'd1);

    // Offset wraps modulo 2^16.
    send(16'hF800, 1'b1, cap);
    chk("wrap_data", cap, 72'h00_0000_0002_0000_0000);
    chk("wrap_cnt", 72'(evt_cnt), 72'd2);

    // Backpressure: second event waits, then captures in the same cycle as the first transfer.
    ipkt_rdy = 1'b0;
    send(16'h0123, 1'b1, cap);
    iaer_data = 16'hABCD; iaer_req = 1'b0;
    exp_q.push_back(pkt_model(16'hABCD));
    repeat (6) @(posedge clk);
    #1;
    chk("bp_ack_held", {71'd0, iaer_ack}, 72'd1);
    chk("bp_data_held", ipkt_data, pkt_model(16'h0123));
    ipkt_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_ack_cap", {71'd0, iaer_ack}, 72'd0);
    chk("bp_data_new", ipkt_data, pkt_model(16'hABCD));
    chk("bp_cnt1", 72'(evt_cnt), 72'd3);
    @(posedge clk); #1;
    chk("bp_cnt2", 72'(evt_cnt), 72'd4);
    chk("bp_vld_clr", {71'd0, ipkt_vld}, 72'd0);
    iaer_req = 1'b1;
    n = 0;
    while (iaer_ack !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_ack_rise", {71'd0, iaer_ack}, 72'd1);

    // Reset mid-handshake: pending packet dropped, no capture until req cycles.
    ipkt_rdy = 1'b0;
    iaer_data = 16'h5555; iaer_req = 1'b0;
    exp_q.push_back(pkt_model(16'h5555));
    repeat (3) @(posedge clk);
    #1;
    chk("mid_vld", {71'd0, ipkt_vld}, 72'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack", {71'd0, iaer_ack}, 72'd1);
    chk("mid_rst_vld", {71'd0, ipkt_vld}, 72'd0);
    void'(exp_q.pop_back());
    rst = 1'b0;
    bad = 1'b0;
    ipkt_rdy = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ipkt_vld || !iaer_ack) bad = 1'b1;
    end
    chk("resync_hold", {71'd0, bad}, 72'd0);
    iaer_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(16'h0042, 1'b1, cap);
    chk("resync_cnt", 72'(evt_cnt), 72'd1);

    // Loopback through the output mapper.
    lb[0] = 16'h0000; lb[1] = 16'h7FFF; lb[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      send(lb[i], 1'b1, cap);
      chk("loopback", 72'(out_map(cap[39:8])), 72'(lb[i]));
    end

    // Random events with random downstream ready.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 1'b0, cap);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #3 ipkt_rdy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("rand_drained", 72'(exp_q.size()), 72'd0);
    chk("rand_cnt", 72'(evt_cnt), 72'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
